retire_trace_monitor: RTL

- Parametrised commit-trace monitor for the pipelined CPU bench.
- Samples one retire event per cycle from the writeback stage and classifies it as NOP, REG, LD, ST or HALT.
- Stamps each event with a zero-based instruction number and buffers it in a FIFO; the trace/log writer drains the FIFO through a valid/ready handshake.
- Keeps instruction and cycle counters, a watchdog timeout, and a halt-drain state machine so the bench knows when it is safe to close files and finish.

---
 rtl/retire_trace_monitor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/retire_trace_monitor.sv
// Commit-trace monitor: classifies writeback retires, numbers them and queues them in a
// first-word-fall-through FIFO for the trace writer. Optional stall statistics: RETIRE_STALL_STATS_EN.
module retire_trace_monitor #(
  parameter int DW         = 16,
  parameter int AW         = 16,
  parameter int RW         = 4,
  parameter int CW         = 32,
  parameter int DEPTH      = 8,
  parameter int MAX_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ret_valid,
  input  logic [AW-1:0] ret_pc,
  input  logic          ret_regwrite,
  input  logic [RW-1:0] ret_reg,
  input  logic [DW-1:0] ret_wdata,
  input  logic          ret_memread,
  input  logic          ret_memwrite,
  input  logic [AW-1:0] ret_addr,
  input  logic [DW-1:0] ret_mdata,
  input  logic          ret_halt,
  output logic          rec_valid,
  input  logic          rec_ready,
  output logic [2:0]    rec_kind,
  output logic [CW-1:0] rec_inum,
  output logic [AW-1:0] rec_pc,
  output logic [RW-1:0] rec_reg,
  output logic [DW-1:0] rec_value,
  output logic [AW-1:0] rec_addr,
  output logic [CW-1:0] inst_count,
  output logic [CW-1:0] cycle_count,
  output logic          overflow,
  output logic          timeout,
  output logic          done
`ifdef RETIRE_STALL_STATS_EN
  ,
  output logic [CW-1:0] stall_cycles,
  output logic [CW-1:0] max_stall_run
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;
  typedef enum logic [2:0] {K_NOP = 3'd0, K_REG = 3'd1, K_LD = 3'd2, K_ST = 3'd3, K_HALT = 3'd4} kind_e;

  typedef struct packed {
    kind_e         kind;
    logic [CW-1:0] inum;
    logic [AW-1:0] pc;
    logic [RW-1:0] rd;
    logic [DW-1:0] value;
    logic [AW-1:0] addr;
  } rec_t;

  state_e        state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [CW-1:0] inst_q, inst_d, cycle_q, cycle_d, cycle_inc;
  logic          overflow_q, overflow_d, timeout_q, timeout_d;
  logic          full, pop, accept, push, drop;
  rec_t          rec_new, head;
  rec_t          mem_q [DEPTH];

  always_comb begin
    rec_new      = '0;
    rec_new.kind = K_NOP;
    rec_new.inum = inst_q;
    rec_new.pc   = ret_pc;
    if (ret_halt) begin
      rec_new.kind = K_HALT;
    end else if (ret_regwrite) begin
      rec_new.kind  = ret_memread ? K_LD : K_REG;
      rec_new.rd    = ret_reg;
      rec_new.value = ret_wdata;
      if (ret_memread) rec_new.addr = ret_addr;
    end else if (ret_memwrite) begin
      rec_new.kind  = K_ST;
      rec_new.value = ret_mdata;
      rec_new.addr  = ret_addr;
    end
  end

  // A full FIFO still takes the new record when the head leaves in the same cycle.
  assign full      = (cnt_q == (PW+1)'(DEPTH));
  assign rec_valid = (cnt_q != '0);
  assign pop       = rec_valid & rec_ready;
  assign accept    = (state_q == ST_RUN) & ret_valid;
  assign push      = accept & (~full | pop);
  assign drop      = accept & full & ~pop;
  assign cycle_inc = cycle_q + CW'(1);

  always_comb begin
    wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + PW'(1) : rptr_q;
    cnt_d      = cnt_q;
    if (push && !pop) cnt_d = cnt_q + (PW+1)'(1);
    if (pop && !push) cnt_d = cnt_q - (PW+1)'(1);
    state_d    = state_q;
    inst_d     = inst_q;
    cycle_d    = cycle_q;
    overflow_d = overflow_q | drop;
    timeout_d  = timeout_q;
    case (state_q)
      ST_RUN: begin
        cycle_d = cycle_inc;
        if (accept) inst_d = inst_q + CW'(1);
        if (accept && ret_halt) state_d = ST_DRAIN;
        if (cycle_inc == CW'(MAX_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cycle_d = cycle_inc;
        if (cnt_d == '0) state_d = ST_DONE;
      end
      ST_DONE: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      inst_q     <= '0;
      cycle_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      cycle_q    <= cycle_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rec_new;
  end

  assign head        = mem_q[rptr_q];
  assign rec_kind    = head.kind;
  assign rec_inum    = head.inum;
  assign rec_pc      = head.pc;
  assign rec_reg     = head.rd;
  assign rec_value   = head.value;
  assign rec_addr    = head.addr;
  assign inst_count  = inst_q;
  assign cycle_count = cycle_q;
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;
  assign done        = (state_q == ST_DONE);

`ifdef RETIRE_STALL_STATS_EN
  logic [CW-1:0] stall_q, stall_d, run_q, run_d, max_q, max_d, run_ext;

  // The run is closed either by a retire or by the final RUN cycle, which still counts.
  always_comb begin
    stall_d = stall_q;
    run_d   = run_q;
    max_d   = max_q;
    run_ext = ret_valid ? run_q : run_q + CW'(1);
    if (state_q == ST_RUN) begin
      if (!ret_valid) stall_d = stall_q + CW'(1);
      run_d = ret_valid ? '0 : run_q + CW'(1);
      if ((ret_valid || state_d != ST_RUN) && run_ext > max_q) max_d = run_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      run_q   <= '0;
      max_q   <= '0;
    end else begin
      stall_q <= stall_d;
      run_q   <= run_d;
      max_q   <= max_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign max_stall_run = max_q;
`endif

endmodule
